// File: rtl/ifetch_req_ctrl.sv
// Instruction-fetch request sequencer: picks the next fetch PC, drives the cache-bus request handshake,
// and tracks outstanding requests so beats belonging to cancelled fetches are dropped.
module ifetch_req_ctrl #(
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cp0_redir_i,
    input  logic [31:0]                    cp0_pc_i,
    input  logic                           sba_redir_i,
    input  logic [31:0]                    sba_pc_i,
    input  logic                           bsc_redir_i,
    input  logic [31:0]                    bsc_pc_i,
    input  logic                           pred_take_i,
    input  logic [31:0]                    pred_dest_i,
    input  logic                           allowin_i,
    output logic                           inst_req_o,
    output logic [31:0]                    inst_addr_o,
    input  logic                           inst_addr_ok_i,
    input  logic                           inst_data_ok_i,
    output logic                           rsp_valid_o,
    output logic [31:0]                    rsp_vaddr_o,
    output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt_o
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT+1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_REDIR} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc;
    logic [31:0]     redir_pc;
    logic            redir_pend;
    logic [31:0]     fifo [MAX_OUT];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   out_cnt, stale_cnt;

    logic            cancel, push, pop;
    logic [31:0]     cancel_pc, nxt_pc;

    always_comb begin
        cancel    = cp0_redir_i | sba_redir_i | bsc_redir_i;
        cancel_pc = cp0_redir_i ? cp0_pc_i : (sba_redir_i ? sba_pc_i : bsc_pc_i);
        nxt_pc    = pred_take_i ? pred_dest_i : {pc[31:4] + 28'd1, 4'b0};
        push      = inst_req_o & inst_addr_ok_i;
        pop       = inst_data_ok_i && (out_cnt != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: a held request must complete before any redirect takes effect
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (inst_req_o && !inst_addr_ok_i) state_nxt = S_HOLD;
            S_HOLD:  if (inst_addr_ok_i) state_nxt = (redir_pend || cancel) ? S_REDIR : S_FETCH;
            S_REDIR: state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        inst_req_o = 1'b0;
        case (state)
            S_FETCH: inst_req_o = allowin_i && (out_cnt != MAX_CNT) && !cancel;
            S_HOLD:  inst_req_o = 1'b1;
            default: inst_req_o = 1'b0;
        endcase
        inst_addr_o = pc;
        rsp_valid_o = pop && (stale_cnt == '0) && !cancel;
        rsp_vaddr_o = fifo[rd_ptr];
        out_cnt_o   = out_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_cnt    <= '0;
            stale_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE:  if (cancel) pc <= cancel_pc;
                S_FETCH: begin
                    if (cancel)    pc <= cancel_pc;
                    else if (push) pc <= nxt_pc;
                end
                S_HOLD:  if (inst_addr_ok_i && !redir_pend && !cancel) pc <= nxt_pc;
                S_REDIR: pc <= cancel ? cancel_pc : redir_pc;
                default: pc <= pc;
            endcase
            redir_pend <= (state == S_HOLD) ? (redir_pend | cancel) : 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            out_cnt <= out_cnt + CW'(push) - CW'(pop);
            // Everything still in flight after a cancel is stale, including a request accepted
            // under a redirect latched during HOLD.
            if (cancel)
                stale_cnt <= out_cnt + CW'(push) - CW'(pop);
            else
                stale_cnt <= stale_cnt - CW'(pop && (stale_cnt != '0)) + CW'(push && redir_pend);
        end
    end

    always_ff @(posedge clk) begin
        if (cancel) redir_pc <= cancel_pc;
        if (push)   fifo[wr_ptr] <= pc;
    end
endmodule

// File: tb/tb_ifetch_req_ctrl.sv
// Randomized scoreboard bench for ifetch_req_ctrl against a queue-based reference model.
module tb_ifetch_req_ctrl;
    localparam int          MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk, rst;
    logic        cp0_redir_i, sba_redir_i, bsc_redir_i, pred_take_i, allowin_i;
    logic [31:0] cp0_pc_i, sba_pc_i, bsc_pc_i, pred_dest_i;
    logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i, rsp_valid_o;
    logic [31:0] inst_addr_o, rsp_vaddr_o;
    logic [2:0]  out_cnt_o;

    ifetch_req_ctrl #(.MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .cp0_redir_i(cp0_redir_i), .cp0_pc_i(cp0_pc_i),
        .sba_redir_i(sba_redir_i), .sba_pc_i(sba_pc_i),
        .bsc_redir_i(bsc_redir_i), .bsc_pc_i(bsc_pc_i),
        .pred_take_i(pred_take_i), .pred_dest_i(pred_dest_i),
        .allowin_i(allowin_i),
        .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
        .rsp_valid_o(rsp_valid_o), .rsp_vaddr_o(rsp_vaddr_o),
        .out_cnt_o(out_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } ent_t;
    typedef struct { bit vld; logic [31:0] addr; } rsp_t;

    ent_t        q[$];
    rsp_t        sb[$];
    logic [31:0] acc_log[$];
    bit          log_en;
    bit          m_idle, m_redir, m_held, m_pend;
    logic [31:0] m_pc, m_ptgt;
    int          n_checks, n_fail;
    bit          done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = RESET_PC; m_idle = 1; m_redir = 0; m_held = 0; m_pend = 0;
    endtask

    // Called after inputs for the cycle are applied: checks outputs, queues expected beat,
    // then advances the model to the state after the coming clock edge.
    task automatic step();
        bit cancel, exp_req, push;
        logic [31:0] tgt, nxt;
        ent_t e;
        rsp_t r;
        #1;
        if (!rst) begin
            model_reset();
            return;
        end
        cancel  = cp0_redir_i || sba_redir_i || bsc_redir_i;
        tgt     = cp0_redir_i ? cp0_pc_i : (sba_redir_i ? sba_pc_i : bsc_pc_i);
        if (m_idle || m_redir) exp_req = 0;
        else if (m_held)       exp_req = 1;
        else                   exp_req = allowin_i && (q.size() < MAX_OUT) && !cancel;
        chk("inst_req", {31'b0, inst_req_o}, {31'b0, exp_req});
        if (exp_req) chk("inst_addr", inst_addr_o, m_pc);
        chk("out_cnt", {29'b0, out_cnt_o}, 32'(q.size()));
        if (inst_data_ok_i) begin
            r.vld  = !q[0].stale && !cancel;
            r.addr = q[0].addr;
            sb.push_back(r);
            void'(q.pop_front());
        end
        push = exp_req && inst_addr_ok_i;
        nxt  = pred_take_i ? pred_dest_i : ((m_pc & 32'hffff_fff0) + 32'd16);
        if (push) begin
            e.addr = m_pc; e.stale = cancel || m_pend;
            q.push_back(e);
            if (log_en) acc_log.push_back(m_pc);
        end
        if (cancel) foreach (q[i]) q[i].stale = 1;
        if (m_idle) begin
            m_idle = 0;
            if (cancel) m_pc = tgt;
        end else if (m_redir) begin
            m_redir = 0;
            m_pc = cancel ? tgt : m_ptgt;
        end else if (m_held) begin
            if (cancel) begin m_pend = 1; m_ptgt = tgt; end
            if (inst_addr_ok_i) begin
                m_held = 0;
                if (m_pend) begin m_redir = 1; m_pend = 0; end
                else m_pc = nxt;
            end
        end else begin
            if (cancel)       m_pc = tgt;
            else if (push)    m_pc = nxt;
            else if (exp_req) m_held = 1;
        end
    endtask

    // Response monitor: pops one expectation per data_ok beat
    initial begin
        rsp_t r;
        while (!done) begin
            @(negedge clk); #2;
            if (!done && rst && inst_data_ok_i) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_underflow: beat seen, expected none queued");
                end else begin
                    r = sb.pop_front();
                    chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, r.vld});
                    if (r.vld) chk("rsp_vaddr", rsp_vaddr_o, r.addr);
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; done = 0; log_en = 0;
        rst = 0;
        cp0_redir_i = 0; sba_redir_i = 0; bsc_redir_i = 0; pred_take_i = 0; allowin_i = 0;
        cp0_pc_i = 0; sba_pc_i = 0; bsc_pc_i = 0; pred_dest_i = 0;
        inst_addr_ok_i = 0; inst_data_ok_i = 0;
        model_reset();
        repeat (2) begin @(negedge clk); step(); end

        // Streaming fetch with no returns: fills to MAX_OUT and stalls
        log_en = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst = 1; allowin_i = 1; inst_addr_ok_i = 1;
            step();
        end
        log_en = 0;
        chk("fill_cnt", {29'b0, out_cnt_o}, 32'd4);
        chk("fill_req", {31'b0, inst_req_o}, 32'd0);
        chk("acc_n", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() >= 3) begin
            chk("acc0", acc_log[0], 32'hbfc00000);
            chk("acc1", acc_log[1], 32'hbfc00010);
            chk("acc2", acc_log[2], 32'hbfc00020);
        end

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 199) != 0);
            cp0_redir_i    = ($urandom_range(0, 19) == 0);
            sba_redir_i    = ($urandom_range(0, 19) == 0);
            bsc_redir_i    = ($urandom_range(0, 15) == 0);
            cp0_pc_i       = $urandom;
            sba_pc_i       = $urandom;
            bsc_pc_i       = $urandom;
            pred_take_i    = ($urandom_range(0, 3) == 0);
            pred_dest_i    = $urandom;
            allowin_i      = ($urandom_range(0, 3) != 0);
            inst_addr_ok_i = $urandom_range(0, 1) == 1;
            inst_data_ok_i = rst && (q.size() > 0) && ($urandom_range(0, 1) == 1);
            step();
        end

        @(negedge clk);
        inst_data_ok_i = 0; cp0_redir_i = 0; sba_redir_i = 0; bsc_redir_i = 0;
        #3;
        done = 1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
